// File: rtl/debounce_arbiter.sv
// debounce_arbiter: debounces N_BTN buttons through one shared, round-robin-granted settle counter.
// Define DEBOUNCE_RELEASE_EN to add the btn_release one-cycle pulse output.
module debounce_arbiter #(
   parameter int N_BTN         = 4,
   parameter int IDX_W         = 2,
   parameter int CNT_W         = 21,
   parameter int SETTLE_CYCLES = 2000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
`ifdef DEBOUNCE_RELEASE_EN
   output logic [N_BTN-1:0] btn_release,
`endif
   output logic             busy,
   output logic [IDX_W-1:0] grant_idx
);
   typedef enum logic [1:0] {IDLE, SETTLE, COMMIT} state_t;
   state_t state, state_n;
   logic [N_BTN-1:0] sync1, sync, cand, level_n, press_n;
   logic [IDX_W-1:0] ptr, ptr_n, grant_n, pick;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic found;
`ifdef DEBOUNCE_RELEASE_EN
   logic [N_BTN-1:0] rel_n;
`endif
   assign cand = sync ^ btn_level;
   assign busy = state != IDLE;
   // first pending candidate after the last served button, wrapping modulo N_BTN
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int k = 1; k <= N_BTN; k++)
         if (!found && cand[IDX_W'((int'(ptr) + k) % N_BTN)]) begin
            pick  = IDX_W'((int'(ptr) + k) % N_BTN);
            found = 1'b1;
         end
   end
   always_comb begin
      state_n = state;
      grant_n = grant_idx;
      cnt_n   = cnt;
      ptr_n   = ptr;
      level_n = btn_level;
      press_n = '0;
`ifdef DEBOUNCE_RELEASE_EN
      rel_n   = '0;
`endif
      case (state)
         IDLE:
            if (|cand) begin
               grant_n = pick;
               cnt_n   = '0;
               state_n = SETTLE;
            end
         SETTLE:
            if (sync[grant_idx] == btn_level[grant_idx]) begin
               ptr_n   = grant_idx;
               state_n = IDLE;
            end else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) state_n = COMMIT;
            else cnt_n = cnt + CNT_W'(1);
         COMMIT: begin
            level_n[grant_idx] = sync[grant_idx];
            press_n[grant_idx] = sync[grant_idx];
`ifdef DEBOUNCE_RELEASE_EN
            rel_n[grant_idx]   = ~sync[grant_idx] & btn_level[grant_idx];
`endif
            ptr_n   = grant_idx;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         sync1       <= '0;
         sync        <= '0;
         state       <= IDLE;
         grant_idx   <= '0;
         cnt         <= '0;
         ptr         <= IDX_W'(N_BTN - 1);
         btn_level   <= '0;
         btn_press   <= '0;
`ifdef DEBOUNCE_RELEASE_EN
         btn_release <= '0;
`endif
      end else begin
         sync1       <= btn_in;
         sync        <= sync1;
         state       <= state_n;
         grant_idx   <= grant_n;
         cnt         <= cnt_n;
         ptr         <= ptr_n;
         btn_level   <= level_n;
         btn_press   <= press_n;
`ifdef DEBOUNCE_RELEASE_EN
         btn_release <= rel_n;
`endif
      end
endmodule
